// File: rtl/ins_fetch_if.sv
// Fetch-stage bus: pipeline control, program-load port and the registered IF/ID outputs.
interface ins_fetch_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              stall;
  logic              redirect_vld;
  logic [ADDR_W-1:0] redirect_pc;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [31:0]       ins_code;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_plus4;
  logic              ins_vld;
  logic              fault;

  modport master (
    output stall, redirect_vld, redirect_pc, wr_en, wr_addr, wr_data,
    input  ins_code, pc_out, pc_plus4, ins_vld, fault
  );

  modport slave (
    input  stall, redirect_vld, redirect_pc, wr_en, wr_addr, wr_data,
    output ins_code, pc_out, pc_plus4, ins_vld, fault
  );
endinterface

// File: rtl/ins_fetch_unit.sv
// Instruction fetch: PC, byte-addressed big-endian store, registered IF/ID output.
// Define FETCH_FAULT_TRAP_EN to halt on a fetch fault until redirect or reset.
module ins_fetch_unit #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH_BYTES = 64,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [31:0]       NOP_WORD    = '0
) (
  input logic        clk,
  input logic        rst,
  ins_fetch_if.slave bus
);
  localparam int unsigned       IDX_W     = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH_BYTES - 4);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

`ifdef FETCH_FAULT_TRAP_EN
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;
  logic [0:0] r_state;
`endif

  logic [7:0]        r_mem [DEPTH_BYTES];
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pc_out;
  logic [ADDR_W-1:0] r_pc_plus4;
  logic [31:0]       r_ins_code;
  logic              r_ins_vld;
  logic              r_fault;

  logic              w_fetch_fault;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [31:0]       w_rd_word;
  logic [ADDR_W-1:0] w_wr_base;
  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_wr_ok;

  always_comb begin
    w_fetch_fault = (r_pc[1:0] != 2'b00) || (r_pc > LAST_WORD);
    w_rd_idx      = r_pc[IDX_W-1:0];
    w_rd_word     = {r_mem[{w_rd_idx[IDX_W-1:2], 2'b00}],
                     r_mem[{w_rd_idx[IDX_W-1:2], 2'b01}],
                     r_mem[{w_rd_idx[IDX_W-1:2], 2'b10}],
                     r_mem[{w_rd_idx[IDX_W-1:2], 2'b11}]};
    w_wr_base     = bus.wr_addr & ~ADDR_W'(3);
    w_wr_idx      = w_wr_base[IDX_W-1:0];
    w_wr_ok       = bus.wr_en && (w_wr_base <= LAST_WORD);
  end

  // Store writes ignore rst/stall/state so a program can be preloaded while held in reset;
  // the fetch below reads the pre-write contents in the same cycle.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[{w_wr_idx[IDX_W-1:2], 2'b00}] <= bus.wr_data[31:24];
      r_mem[{w_wr_idx[IDX_W-1:2], 2'b01}] <= bus.wr_data[23:16];
      r_mem[{w_wr_idx[IDX_W-1:2], 2'b10}] <= bus.wr_data[15:8];
      r_mem[{w_wr_idx[IDX_W-1:2], 2'b11}] <= bus.wr_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_pc_out   <= RESET_PC;
      r_pc_plus4 <= RESET_PC + PC_STEP;
      r_ins_code <= NOP_WORD;
      r_ins_vld  <= 1'b0;
      r_fault    <= 1'b0;
`ifdef FETCH_FAULT_TRAP_EN
      r_state    <= ST_RUN;
`endif
    end else if (bus.redirect_vld) begin
      r_pc       <= bus.redirect_pc;
      r_ins_code <= NOP_WORD;
      r_ins_vld  <= 1'b0;
      r_fault    <= 1'b0;
`ifdef FETCH_FAULT_TRAP_EN
      r_state    <= ST_RUN;
`endif
    end else if (!bus.stall) begin
`ifdef FETCH_FAULT_TRAP_EN
      if (r_state == ST_HALT) begin
        r_ins_code <= NOP_WORD;
        r_ins_vld  <= 1'b0;
        r_fault    <= 1'b1;
      end else if (w_fetch_fault) begin
        r_pc_out   <= r_pc;
        r_pc_plus4 <= r_pc + PC_STEP;
        r_ins_code <= NOP_WORD;
        r_ins_vld  <= 1'b0;
        r_fault    <= 1'b1;
        r_state    <= ST_HALT;
      end else begin
        r_pc       <= r_pc + PC_STEP;
        r_pc_out   <= r_pc;
        r_pc_plus4 <= r_pc + PC_STEP;
        r_ins_code <= w_rd_word;
        r_ins_vld  <= 1'b1;
        r_fault    <= 1'b0;
      end
`else
      r_pc       <= r_pc + PC_STEP;
      r_pc_out   <= r_pc;
      r_pc_plus4 <= r_pc + PC_STEP;
      r_ins_code <= w_fetch_fault ? NOP_WORD : w_rd_word;
      r_ins_vld  <= !w_fetch_fault;
      r_fault    <= w_fetch_fault;
`endif
    end
  end

  assign bus.ins_code = r_ins_code;
  assign bus.pc_out   = r_pc_out;
  assign bus.pc_plus4 = r_pc_plus4;
  assign bus.ins_vld  = r_ins_vld;
  assign bus.fault    = r_fault;
endmodule
